// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings plus the response-merge and per-beat address-step helpers.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The encodings already rank by severity, so the worst response is the numeric max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // WRAP steps like INCR; the caller flags WRAP bursts as SLVERR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        if (burst == BURST_FIXED) return addr;
        return addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM: byte-enabled write port, registered read-first read port.
module sdp_bram #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic [WIDTH/8-1:0]    we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rdata_q;

    // Both updates are non-blocking, so a same-edge read sees the pre-write word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH / 8; i++) begin
            if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory on an inferred BRAM; independent write and read FSMs, one burst outstanding per direction.
module axi4_mem_responder
    import axi4_pkg::*;
#(
    parameter int                   ADDR_BITS      = 32,
    parameter int                   DATA_BITS      = 64,
    parameter int                   ID_BITS        = 6,
    parameter int                   MEM_WORDS_LOG2 = 14,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR      = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_axi_aw_valid,
    output logic                   io_axi_aw_ready,
    input  logic [ADDR_BITS-1:0]   io_axi_aw_bits_addr,
    input  logic [ID_BITS-1:0]     io_axi_aw_bits_id,
    input  logic [7:0]             io_axi_aw_bits_len,
    input  logic [2:0]             io_axi_aw_bits_size,
    input  logic [1:0]             io_axi_aw_bits_burst,
    input  logic                   io_axi_w_valid,
    output logic                   io_axi_w_ready,
    input  logic [DATA_BITS-1:0]   io_axi_w_bits_data,
    input  logic [DATA_BITS/8-1:0] io_axi_w_bits_strb,
    input  logic                   io_axi_w_bits_last,
    output logic                   io_axi_b_valid,
    input  logic                   io_axi_b_ready,
    output logic [ID_BITS-1:0]     io_axi_b_bits_id,
    output logic [1:0]             io_axi_b_bits_resp,
    input  logic                   io_axi_ar_valid,
    output logic                   io_axi_ar_ready,
    input  logic [ADDR_BITS-1:0]   io_axi_ar_bits_addr,
    input  logic [ID_BITS-1:0]     io_axi_ar_bits_id,
    input  logic [7:0]             io_axi_ar_bits_len,
    input  logic [2:0]             io_axi_ar_bits_size,
    input  logic [1:0]             io_axi_ar_bits_burst,
    output logic                   io_axi_r_valid,
    input  logic                   io_axi_r_ready,
    output logic [DATA_BITS-1:0]   io_axi_r_bits_data,
    output logic [ID_BITS-1:0]     io_axi_r_bits_id,
    output logic [1:0]             io_axi_r_bits_resp,
    output logic                   io_axi_r_bits_last
);

    localparam int HI = MEM_WORDS_LOG2 + 3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

    // BASE_ADDR is size-aligned, so the region test is an upper-bit compare.
    function automatic logic in_region(input logic [ADDR_BITS-1:0] a);
        return a[ADDR_BITS-1:HI] == BASE_ADDR[ADDR_BITS-1:HI];
    endfunction

    function automatic logic [1:0] beat_resp(input logic [ADDR_BITS-1:0] a, input logic [2:0] size,
                                             input logic [1:0] burst);
        if (!in_region(a)) return RESP_DECERR;
        if (size > 3'd3 || burst == BURST_WRAP) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    wstate_e                wstate_q, wstate_d;
    logic [ADDR_BITS-1:0]   waddr_q, waddr_d;
    logic [ID_BITS-1:0]     wid_q, wid_d;
    logic [7:0]             wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [2:0]             wsize_q, wsize_d;
    logic [1:0]             wburst_q, wburst_d, bresp_q, bresp_d;
    logic [DATA_BITS/8-1:0] ram_we;
    logic                   w_at_len;

    rstate_e                rstate_q, rstate_d;
    logic [ADDR_BITS-1:0]   raddr_q, raddr_d;
    logic [ID_BITS-1:0]     rid_q, rid_d;
    logic [7:0]             rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [2:0]             rsize_q, rsize_d;
    logic [1:0]             rburst_q, rburst_d, rresp_q, rresp_d;
    logic                   rlast_q, rlast_d;
    logic [DATA_BITS-1:0]   ram_rdata;

    assign io_axi_aw_ready    = (wstate_q == W_IDLE);
    assign io_axi_w_ready     = (wstate_q == W_DATA);
    assign io_axi_b_valid     = (wstate_q == W_RESP);
    assign io_axi_b_bits_id   = wid_q;
    assign io_axi_b_bits_resp = bresp_q;

    assign io_axi_ar_ready    = (rstate_q == R_IDLE);
    assign io_axi_r_valid     = (rstate_q == R_DATA);
    assign io_axi_r_bits_id   = rid_q;
    assign io_axi_r_bits_resp = rresp_q;
    assign io_axi_r_bits_last = rlast_q;
    assign io_axi_r_bits_data = (io_axi_r_valid && rresp_q != RESP_DECERR) ? ram_rdata : '0;

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wid_d    = wid_q;
        wlen_d   = wlen_q;
        wsize_d  = wsize_q;
        wburst_d = wburst_q;
        wbeat_d  = wbeat_q;
        bresp_d  = bresp_q;
        ram_we   = '0;
        w_at_len = (wbeat_q == wlen_q);
        case (wstate_q)
            W_IDLE: if (io_axi_aw_valid) begin
                waddr_d  = io_axi_aw_bits_addr;
                wid_d    = io_axi_aw_bits_id;
                wlen_d   = io_axi_aw_bits_len;
                wsize_d  = io_axi_aw_bits_size;
                wburst_d = io_axi_aw_bits_burst;
                wbeat_d  = '0;
                bresp_d  = RESP_OKAY;
                wstate_d = W_DATA;
            end
            W_DATA: if (io_axi_w_valid) begin
                if (in_region(waddr_q)) ram_we = io_axi_w_bits_strb;
                bresp_d = resp_max(bresp_q, beat_resp(waddr_q, wsize_q, wburst_q));
                // Early or missing w_last terminates the burst but marks it bad.
                if (io_axi_w_bits_last != w_at_len) bresp_d = resp_max(bresp_d, RESP_SLVERR);
                waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
                wbeat_d = wbeat_q + 8'd1;
                if (io_axi_w_bits_last || w_at_len) wstate_d = W_RESP;
            end
            W_RESP: if (io_axi_b_ready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rid_d    = rid_q;
        rlen_d   = rlen_q;
        rsize_d  = rsize_q;
        rburst_d = rburst_q;
        rbeat_d  = rbeat_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        case (rstate_q)
            R_IDLE: if (io_axi_ar_valid) begin
                raddr_d  = io_axi_ar_bits_addr;
                rid_d    = io_axi_ar_bits_id;
                rlen_d   = io_axi_ar_bits_len;
                rsize_d  = io_axi_ar_bits_size;
                rburst_d = io_axi_ar_bits_burst;
                rbeat_d  = '0;
                rstate_d = R_ADDR;
            end
            R_ADDR: begin
                rresp_d  = beat_resp(raddr_q, rsize_q, rburst_q);
                rlast_d  = (rbeat_q == rlen_q);
                rstate_d = R_DATA;
            end
            R_DATA: if (io_axi_r_ready) begin
                if (rlast_q) begin
                    rstate_d = R_IDLE;
                end else begin
                    raddr_d  = next_addr(raddr_q, rsize_q, rburst_q);
                    rbeat_d  = rbeat_q + 8'd1;
                    rstate_d = R_ADDR;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            wid_q    <= '0;
            wlen_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wbeat_q  <= '0;
            bresp_q  <= RESP_OKAY;
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rid_q    <= '0;
            rlen_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rbeat_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            wid_q    <= wid_d;
            wlen_q   <= wlen_d;
            wsize_q  <= wsize_d;
            wburst_q <= wburst_d;
            wbeat_q  <= wbeat_d;
            bresp_q  <= bresp_d;
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rid_q    <= rid_d;
            rlen_q   <= rlen_d;
            rsize_q  <= rsize_d;
            rburst_q <= rburst_d;
            rbeat_q  <= rbeat_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    sdp_bram #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (MEM_WORDS_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr_q[HI-1:3]),
        .wdata (io_axi_w_bits_data),
        .re    (rstate_q == R_ADDR),
        .raddr (raddr_q[HI-1:3]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: one task per scenario, hand-computed expectations.
module tb_axi4_mem_responder;

    localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;
    localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [31:0] aw_addr, ar_addr;
    logic [5:0]  aw_id, ar_id, b_id, r_id;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [63:0] w_data, r_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi4_mem_responder dut (
        .clk(clk), .reset(reset),
        .io_axi_aw_valid(aw_valid), .io_axi_aw_ready(aw_ready), .io_axi_aw_bits_addr(aw_addr),
        .io_axi_aw_bits_id(aw_id), .io_axi_aw_bits_len(aw_len), .io_axi_aw_bits_size(aw_size),
        .io_axi_aw_bits_burst(aw_burst),
        .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready), .io_axi_w_bits_data(w_data),
        .io_axi_w_bits_strb(w_strb), .io_axi_w_bits_last(w_last),
        .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready), .io_axi_b_bits_id(b_id),
        .io_axi_b_bits_resp(b_resp),
        .io_axi_ar_valid(ar_valid), .io_axi_ar_ready(ar_ready), .io_axi_ar_bits_addr(ar_addr),
        .io_axi_ar_bits_id(ar_id), .io_axi_ar_bits_len(ar_len), .io_axi_ar_bits_size(ar_size),
        .io_axi_ar_bits_burst(ar_burst),
        .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready), .io_axi_r_bits_data(r_data),
        .io_axi_r_bits_id(r_id), .io_axi_r_bits_resp(r_resp), .io_axi_r_bits_last(r_last)
    );

    // Driver tasks start and end at posedge+1; ready/valid are sampled on the falling edge.
    task automatic send_aw(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        aw_addr = a; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (aw_ready) begin @(posedge clk); #1; aw_valid = 1'b0; return; end
        end
        aw_valid = 1'b0; total++; bad++;
        $display("FAIL aw_timeout got aw_ready=0 for 64 cycles want 1");
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        ar_addr = a; ar_id = id; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ar_ready) begin @(posedge clk); #1; ar_valid = 1'b0; return; end
        end
        ar_valid = 1'b0; total++; bad++;
        $display("FAIL ar_timeout got ar_ready=0 for 64 cycles want 1");
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
        w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (w_ready) begin @(posedge clk); #1; w_valid = 1'b0; return; end
        end
        w_valid = 1'b0; total++; bad++;
        $display("FAIL w_timeout got w_ready=0 for 64 cycles want 1");
    endtask

    task automatic recv_b(output logic [5:0] id, output logic [1:0] resp);
        id = 'x; resp = 'x; b_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (b_valid) begin
                id = b_id; resp = b_resp;
                @(posedge clk); #1; b_ready = 1'b0; return;
            end
        end
        b_ready = 1'b0; total++; bad++;
        $display("FAIL b_timeout got b_valid=0 for 64 cycles want 1");
    endtask

    task automatic recv_r(output logic [63:0] d, output logic [5:0] id, output logic [1:0] resp,
                          output logic l);
        d = 'x; id = 'x; resp = 'x; l = 1'bx; r_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (r_valid) begin
                d = r_data; id = r_id; resp = r_resp; l = r_last;
                @(posedge clk); #1; r_ready = 1'b0; return;
            end
        end
        r_ready = 1'b0; total++; bad++;
        $display("FAIL r_timeout got r_valid=0 for 64 cycles want 1");
    endtask

    task automatic test_reset();
        total++; if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin bad++;
            $display("FAIL reset_ready got aw=%b ar=%b want 1 1", aw_ready, ar_ready); end
        total++; if (w_ready !== 1'b0 || b_valid !== 1'b0 || r_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid got w_rdy=%b b=%b r=%b want 0 0 0", w_ready, b_valid, r_valid); end
        total++; if ({b_id, b_resp, r_id, r_resp, r_last} !== 17'd0 || r_data !== 64'd0) begin bad++;
            $display("FAIL reset_bits got b_id=%h b_resp=%h r_id=%h r_resp=%h r_last=%b r_data=%h want all 0",
                     b_id, b_resp, r_id, r_resp, r_last, r_data); end
    endtask

    task automatic test_single();
        logic [5:0] id; logic [1:0] rs; logic [63:0] d; logic l;
        send_aw(32'h40, 6'h05, 8'd0, 3'd3, INCR);
        send_w(64'h1122334455667788, 8'hFF, 1'b1);
        recv_b(id, rs);
        total++; if (id !== 6'h05 || rs !== OKAY) begin bad++;
            $display("FAIL single_b got id=%h resp=%h want 05 0", id, rs); end
        send_ar(32'h40, 6'h09, 8'd0, 3'd3, INCR);
        recv_r(d, id, rs, l);
        total++; if (d !== 64'h1122334455667788) begin bad++;
            $display("FAIL single_rdata got %h want 1122334455667788", d); end
        total++; if (id !== 6'h09 || rs !== OKAY || l !== 1'b1) begin bad++;
            $display("FAIL single_rbits got id=%h resp=%h last=%b want 09 0 1", id, rs, l); end
    endtask

    task automatic test_incr();
        logic [5:0] id; logic [1:0] rs; logic [63:0] first;
        send_aw(32'h100, 6'h11, 8'd7, 3'd3, INCR);
        for (int i = 0; i < 8; i++) send_w(64'(i), 8'hFF, i == 7);
        recv_b(id, rs);
        total++; if (id !== 6'h11 || rs !== OKAY) begin bad++;
            $display("FAIL incr_b got id=%h resp=%h want 11 0", id, rs); end
        send_ar(32'h100, 6'h12, 8'd7, 3'd3, INCR);
        for (int b = 0; b < 8; b++) begin
            int n, stall;
            n = 0;
            while (!r_valid && n < 20) begin @(posedge clk); #1; n++; end
            total++; if (r_valid !== 1'b1) begin bad++;
                $display("FAIL incr_rvalid beat=%0d got 0 want 1", b); end
            first = r_data;
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                total++; if (r_valid !== 1'b1 || r_data !== first) begin bad++;
                    $display("FAIL incr_stall beat=%0d got valid=%b data=%h want 1 %h", b, r_valid, r_data, first); end
            end
            total++; if (r_data !== 64'(b) || r_last !== (b == 7) || r_resp !== OKAY || r_id !== 6'h12) begin bad++;
                $display("FAIL incr_beat beat=%0d got data=%h last=%b resp=%h id=%h want %h %b 0 12",
                         b, r_data, r_last, r_resp, r_id, 64'(b), b == 7); end
            r_ready = 1'b1; @(posedge clk); #1; r_ready = 1'b0;
        end
    endtask

    task automatic test_strobe_narrow();
        logic [5:0] id; logic [1:0] rs; logic [63:0] d; logic l;
        send_aw(32'h200, 6'h01, 8'd0, 3'd3, INCR);
        send_w(64'h0, 8'hFF, 1'b1);
        recv_b(id, rs);
        send_aw(32'h200, 6'h02, 8'd0, 3'd3, INCR);
        send_w(64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1);
        recv_b(id, rs);
        send_aw(32'h204, 6'h03, 8'd1, 3'd0, INCR);
        send_w(64'h000000BB00000000, 8'h10, 1'b0);
        send_w(64'h0000BB0000000000, 8'h20, 1'b1);
        recv_b(id, rs);
        total++; if (id !== 6'h03 || rs !== OKAY) begin bad++;
            $display("FAIL narrow_b got id=%h resp=%h want 03 0", id, rs); end
        send_ar(32'h200, 6'h04, 8'd0, 3'd3, INCR);
        recv_r(d, id, rs, l);
        total++; if (d !== 64'h0000BBBBAAAAAAAA) begin bad++;
            $display("FAIL narrow_rdata got %h want 0000bbbbaaaaaaaa", d); end
    endtask

    task automatic test_out_of_range();
        logic [5:0] id; logic [1:0] rs; logic [63:0] d; logic l;
        send_aw(32'h0, 6'h01, 8'd0, 3'd3, INCR);
        send_w(64'h0123456789ABCDEF, 8'hFF, 1'b1);
        recv_b(id, rs);
        send_aw(32'h1FFF8, 6'h02, 8'd0, 3'd3, INCR);
        send_w(64'hFEEDFACECAFEBEEF, 8'hFF, 1'b1);
        recv_b(id, rs);
        send_aw(32'h20000, 6'h2E, 8'd1, 3'd3, INCR);
        send_w(64'hDEADDEADDEADDEAD, 8'hFF, 1'b0);
        send_w(64'hDEADDEADDEADDEAD, 8'hFF, 1'b1);
        recv_b(id, rs);
        total++; if (id !== 6'h2E || rs !== DECERR) begin bad++;
            $display("FAIL oor_b got id=%h resp=%h want 2e 3", id, rs); end
        send_ar(32'h0, 6'h03, 8'd0, 3'd3, INCR);
        recv_r(d, id, rs, l);
        total++; if (d !== 64'h0123456789ABCDEF || rs !== OKAY) begin bad++;
            $display("FAIL oor_untouched got data=%h resp=%h want 0123456789abcdef 0", d, rs); end
        send_ar(32'h1FFF8, 6'h04, 8'd1, 3'd3, INCR);
        recv_r(d, id, rs, l);
        total++; if (d !== 64'hFEEDFACECAFEBEEF || rs !== OKAY || l !== 1'b0) begin bad++;
            $display("FAIL oor_beat0 got data=%h resp=%h last=%b want feedfacecafebeef 0 0", d, rs, l); end
        recv_r(d, id, rs, l);
        total++; if (d !== 64'h0 || rs !== DECERR || l !== 1'b1) begin bad++;
            $display("FAIL oor_beat1 got data=%h resp=%h last=%b want 0 3 1", d, rs, l); end
    endtask

    task automatic test_slverr();
        logic [5:0] id; logic [1:0] rs; logic [63:0] d; logic l;
        send_aw(32'h600, 6'h21, 8'd0, 3'd3, WRAP);
        send_w(64'h5A5A5A5A5A5A5A5A, 8'hFF, 1'b1);
        recv_b(id, rs);
        total++; if (rs !== SLVERR) begin bad++;
            $display("FAIL wrap_b got resp=%h want 2", rs); end
        send_ar(32'h600, 6'h22, 8'd0, 3'd3, WRAP);
        recv_r(d, id, rs, l);
        total++; if (d !== 64'h5A5A5A5A5A5A5A5A || rs !== SLVERR) begin bad++;
            $display("FAIL wrap_r got data=%h resp=%h want 5a5a5a5a5a5a5a5a 2", d, rs); end
        send_aw(32'h680, 6'h23, 8'd1, 3'd3, INCR);
        send_w(64'h77, 8'hFF, 1'b1);
        recv_b(id, rs);
        total++; if (id !== 6'h23 || rs !== SLVERR) begin bad++;
            $display("FAIL early_last_b got id=%h resp=%h want 23 2", id, rs); end
        send_ar(32'h600, 6'h24, 8'd0, 3'd4, INCR);
        recv_r(d, id, rs, l);
        total++; if (rs !== SLVERR || d !== 64'h5A5A5A5A5A5A5A5A) begin bad++;
            $display("FAIL size4_r got data=%h resp=%h want 5a5a5a5a5a5a5a5a 2", d, rs); end
    endtask

    task automatic test_concurrent();
        logic [5:0] wid, rid; logic [1:0] wrs, rrs; logic [63:0] d; logic l;
        fork
            begin
                send_aw(32'h900, 6'h15, 8'd3, 3'd3, INCR);
                for (int i = 0; i < 4; i++) send_w(64'hC0 + 64'(i), 8'hFF, i == 3);
                recv_b(wid, wrs);
                total++; if (wid !== 6'h15 || wrs !== OKAY) begin bad++;
                    $display("FAIL conc_b got id=%h resp=%h want 15 0", wid, wrs); end
            end
            begin
                send_ar(32'h100, 6'h2A, 8'd3, 3'd3, INCR);
                for (int i = 0; i < 4; i++) begin
                    recv_r(d, rid, rrs, l);
                    total++; if (d !== 64'(i) || rid !== 6'h2A || l !== (i == 3)) begin bad++;
                        $display("FAIL conc_r beat=%0d got data=%h id=%h last=%b want %h 2a %b",
                                 i, d, rid, l, 64'(i), i == 3); end
                end
            end
        join
        send_ar(32'h900, 6'h2B, 8'd3, 3'd3, INCR);
        for (int i = 0; i < 4; i++) begin
            recv_r(d, rid, rrs, l);
            total++; if (d !== 64'hC0 + 64'(i)) begin bad++;
                $display("FAIL conc_readback beat=%0d got %h want %h", i, d, 64'hC0 + 64'(i)); end
        end
    endtask

    task automatic test_collision();
        logic [5:0] id; logic [1:0] rs; logic [63:0] d; logic l;
        send_aw(32'h300, 6'h01, 8'd0, 3'd3, INCR);
        send_w(64'h1111111111111111, 8'hFF, 1'b1);
        recv_b(id, rs);
        send_aw(32'h300, 6'h02, 8'd0, 3'd3, INCR);
        // ar fires this edge; the RAM read and the w beat then land on the same following edge
        ar_addr = 32'h300; ar_id = 6'h03; ar_len = 8'd0; ar_size = 3'd3; ar_burst = INCR; ar_valid = 1'b1;
        @(posedge clk); #1; ar_valid = 1'b0;
        w_data = 64'h2222222222222222; w_strb = 8'hFF; w_last = 1'b1; w_valid = 1'b1;
        @(posedge clk); #1; w_valid = 1'b0;
        recv_r(d, id, rs, l);
        total++; if (d !== 64'h1111111111111111) begin bad++;
            $display("FAIL collide_old got %h want 1111111111111111", d); end
        recv_b(id, rs);
        send_ar(32'h300, 6'h04, 8'd0, 3'd3, INCR);
        recv_r(d, id, rs, l);
        total++; if (d !== 64'h2222222222222222) begin bad++;
            $display("FAIL collide_new got %h want 2222222222222222", d); end
    endtask

    task automatic test_reset_mid_burst();
        logic [5:0] id; logic [1:0] rs; logic [63:0] d; logic l;
        send_aw(32'h500, 6'h07, 8'd7, 3'd3, INCR);
        for (int i = 0; i < 3; i++) send_w(64'h50 + 64'(i), 8'hFF, 1'b0);
        w_data = 64'h53; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; w_valid = 1'b0;
        total++; if (b_valid !== 1'b0 || aw_ready !== 1'b1 || w_ready !== 1'b0) begin bad++;
            $display("FAIL rst_mid got b_valid=%b aw_ready=%b w_ready=%b want 0 1 0", b_valid, aw_ready, w_ready); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (b_valid !== 1'b0) begin bad++;
            $display("FAIL rst_no_b got b_valid=%b want 0", b_valid); end
        send_aw(32'h580, 6'h09, 8'd0, 3'd3, INCR);
        send_w(64'h99, 8'hFF, 1'b1);
        recv_b(id, rs);
        total++; if (id !== 6'h09 || rs !== OKAY) begin bad++;
            $display("FAIL rst_after_b got id=%h resp=%h want 09 0", id, rs); end
        send_ar(32'h500, 6'h0A, 8'd0, 3'd3, INCR);
        recv_r(d, id, rs, l);
        total++; if (d !== 64'h50) begin bad++;
            $display("FAIL rst_partial got %h want 50", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_single();
        test_incr();
        test_strobe_narrow();
        test_out_of_range();
        test_slverr();
        test_concurrent();
        test_collision();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
